// File: rtl/oled_pkg.sv
// -----------------------------------------------------------------------------
// oled_pkg
// Shared constants and helpers for the OLED 4-wire SPI receive path.
//   DC_DATA / DC_CMD       : meaning of the dc line
//   CMD_*                  : base codes of the addressing commands tracked
//   OLED_COLS / OLED_PAGES : default display geometry
//   rx_state_e             : serial frame state (idle / shifting)
// -----------------------------------------------------------------------------
package oled_pkg;

    localparam logic DC_DATA = 1'b1;
    localparam logic DC_CMD  = 1'b0;

    localparam logic [7:0] CMD_PAGE_BASE = 8'hB0;
    localparam logic [7:0] CMD_COL_LO    = 8'h00;
    localparam logic [7:0] CMD_COL_HI    = 8'h10;

    localparam int unsigned OLED_COLS  = 128;
    localparam int unsigned OLED_PAGES = 8;

    typedef enum logic {
        RX_IDLE  = 1'b0,
        RX_SHIFT = 1'b1
    } rx_state_e;

    // 0xB0..0xB7: set page
    function automatic logic is_page_cmd(input logic [7:0] b);
        return (b & 8'hF8) == CMD_PAGE_BASE;
    endfunction

    // 0x00..0x0F: set low nibble of column
    function automatic logic is_col_lo_cmd(input logic [7:0] b);
        return (b & 8'hF0) == CMD_COL_LO;
    endfunction

    // 0x10..0x17: set upper three column bits; 0x18..0x1F deliberately excluded
    function automatic logic is_col_hi_cmd(input logic [7:0] b);
        return (b & 8'hF8) == CMD_COL_HI;
    endfunction

endpackage

// File: rtl/oled_spi_rx_if.sv
// -----------------------------------------------------------------------------
// oled_spi_rx_if
// Bundle of the OLED serial lines (driven by the transmitter side) and the
// decoded byte / GRAM write results (driven by the receiver).
//   slave  : the receiver (oled_spi_rx)
//   master : whoever drives the serial lines and consumes the results
// -----------------------------------------------------------------------------
interface oled_spi_rx_if;

    logic       cs_n;
    logic       sclk;
    logic       dc;
    logic       sdin;
    logic       oled_rst;

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_dc;
    logic       gram_we;
    logic [9:0] gram_addr;
    logic [7:0] gram_wdata;
    logic [2:0] cur_page;
    logic [6:0] cur_col;
    logic       frame_err;

    modport slave (
        input  cs_n, sclk, dc, sdin, oled_rst,
        output byte_valid, byte_data, byte_dc, gram_we, gram_addr,
               gram_wdata, cur_page, cur_col, frame_err
    );

    modport master (
        output cs_n, sclk, dc, sdin, oled_rst,
        input  byte_valid, byte_data, byte_dc, gram_we, gram_addr,
               gram_wdata, cur_page, cur_col, frame_err
    );

endinterface

// File: rtl/oled_spi_rx_shifter.sv
// -----------------------------------------------------------------------------
// oled_spi_rx_shifter
// Synchronizes the asynchronous serial lines, detects sclk rising edges and
// reassembles MSB-first bytes.
//   clk, rst          : system clock, synchronous active-high reset
//   cs_n_i .. oled_rst_i : raw serial pins
//   byte_valid_o      : one-clk pulse per completed byte
//   byte_data_o       : last completed byte (held)
//   byte_dc_o         : dc sampled together with bit 0
//   frame_err_o       : sticky, cs_n rose with a partial byte in the shifter
//   oled_rst_s_o      : synchronized display reset (active low)
// -----------------------------------------------------------------------------
module oled_spi_rx_shifter
    import oled_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs_n_i,
    input  logic       sclk_i,
    input  logic       dc_i,
    input  logic       sdin_i,
    input  logic       oled_rst_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_data_o,
    output logic       byte_dc_o,
    output logic       frame_err_o,
    output logic       oled_rst_s_o
);

    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] dc_sync_q;
    logic [SYNC_STAGES-1:0] sdin_sync_q;
    logic [SYNC_STAGES-1:0] orst_sync_q;
    logic                   sclk_prev_q;

    logic cs_s, sclk_s, dc_s, sdin_s, orst_s, sclk_rise_s, shift_ok_s;

    rx_state_e  state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] cnt_q, cnt_d;
    logic       valid_q, valid_d;
    logic [7:0] data_q, data_d;
    logic       bdc_q, bdc_d;
    logic       ferr_q, ferr_d;

    // Synchronizer chains; reset to the idle levels of each line.
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_sync_q   <= {SYNC_STAGES{1'b1}};
            sclk_sync_q <= {SYNC_STAGES{1'b0}};
            dc_sync_q   <= {SYNC_STAGES{1'b0}};
            sdin_sync_q <= {SYNC_STAGES{1'b0}};
            orst_sync_q <= {SYNC_STAGES{1'b0}};
            sclk_prev_q <= 1'b0;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n_i};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
            dc_sync_q   <= {dc_sync_q[SYNC_STAGES-2:0], dc_i};
            sdin_sync_q <= {sdin_sync_q[SYNC_STAGES-2:0], sdin_i};
            orst_sync_q <= {orst_sync_q[SYNC_STAGES-2:0], oled_rst_i};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
        end
    end

    assign cs_s        = cs_sync_q[SYNC_STAGES-1];
    assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    assign dc_s        = dc_sync_q[SYNC_STAGES-1];
    assign sdin_s      = sdin_sync_q[SYNC_STAGES-1];
    assign orst_s      = orst_sync_q[SYNC_STAGES-1];
    assign sclk_rise_s = sclk_s & ~sclk_prev_q;
    // Still shifting in the cycle cs_n is seen high, so a last-bit edge that
    // coincides with deselect completes its byte.
    assign shift_ok_s  = ~cs_s | (state_q == RX_SHIFT);

    // State, shifter and byte output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RX_IDLE;
            shift_q <= 8'h00;
            cnt_q   <= 3'd0;
            valid_q <= 1'b0;
            data_q  <= 8'h00;
            bdc_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            bdc_q   <= bdc_d;
            ferr_q  <= ferr_d;
        end
    end

    // Frame state, bit assembly and deselect handling.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        data_d  = data_q;
        bdc_d   = bdc_q;
        ferr_d  = ferr_q;

        case (state_q)
            RX_IDLE:  state_d = cs_s ? RX_IDLE : RX_SHIFT;
            RX_SHIFT: state_d = cs_s ? RX_IDLE : RX_SHIFT;
            default:  state_d = RX_IDLE;
        endcase

        if (!orst_s) begin
            shift_d = 8'h00;
            cnt_d   = 3'd0;
        end else begin
            if (sclk_rise_s && shift_ok_s) begin
                shift_d = {shift_q[6:0], sdin_s};
                cnt_d   = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    valid_d = 1'b1;
                    data_d  = {shift_q[6:0], sdin_s};
                    bdc_d   = dc_s;
                end else begin
                    valid_d = 1'b0;
                end
            end else begin
                shift_d = shift_q;
            end
            // Deselect drops any partial byte; cnt_d already reflects a
            // coincident final edge, so a completed byte is not an error.
            if (cs_s) begin
                if (cnt_d != 3'd0) begin
                    ferr_d = 1'b1;
                end else begin
                    ferr_d = ferr_q;
                end
                cnt_d   = 3'd0;
                shift_d = 8'h00;
            end else begin
                ferr_d = ferr_q;
            end
        end
    end

    assign byte_valid_o = valid_q;
    assign byte_data_o  = data_q;
    assign byte_dc_o    = bdc_q;
    assign frame_err_o  = ferr_q;
    assign oled_rst_s_o = orst_s;

endmodule

// File: rtl/oled_spi_rx.sv
// -----------------------------------------------------------------------------
// oled_spi_rx
// OLED 4-wire SPI receiver: byte reassembly (oled_spi_rx_shifter), command
// decode of page/column addressing and one GRAM write per data byte.
//   clk, rst : system clock (>= 6x sclk), synchronous active-high reset
//   rx_io    : serial inputs and byte / GRAM / pointer outputs (slave side)
// -----------------------------------------------------------------------------
module oled_spi_rx
    import oled_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned COLS        = OLED_COLS,
    parameter int unsigned PAGES       = OLED_PAGES
) (
    input  logic         clk,
    input  logic         rst,
    oled_spi_rx_if.slave rx_io
);

    logic       bv_s;
    logic [7:0] bdata_s;
    logic       bdc_s;
    logic       ferr_s;
    logic       orst_s;

    logic [2:0] page_q, page_d;
    logic [6:0] col_q, col_d;
    logic       we_q, we_d;
    logic [9:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;

    oled_spi_rx_shifter #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_shifter (
        .clk          (clk),
        .rst          (rst),
        .cs_n_i       (rx_io.cs_n),
        .sclk_i       (rx_io.sclk),
        .dc_i         (rx_io.dc),
        .sdin_i       (rx_io.sdin),
        .oled_rst_i   (rx_io.oled_rst),
        .byte_valid_o (bv_s),
        .byte_data_o  (bdata_s),
        .byte_dc_o    (bdc_s),
        .frame_err_o  (ferr_s),
        .oled_rst_s_o (orst_s)
    );

    // Pointer and GRAM write port registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            page_q  <= 3'd0;
            col_q   <= 7'd0;
            we_q    <= 1'b0;
            addr_q  <= 10'd0;
            wdata_q <= 8'h00;
        end else begin
            page_q  <= page_d;
            col_q   <= col_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Decode each received byte: addressing commands or a GRAM write.
    always_comb begin
        page_d  = page_q;
        col_d   = col_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        if (!orst_s) begin
            page_d = 3'd0;
            col_d  = 7'd0;
        end else if (bv_s) begin
            if (bdc_s == DC_DATA) begin
                we_d    = 1'b1;
                addr_d  = 10'(10'(page_q) * 10'(COLS)) + 10'(col_q);
                wdata_d = bdata_s;
                // Page addressing mode: column wraps, page stays put.
                col_d   = (col_q == 7'(COLS - 1)) ? 7'd0 : col_q + 7'd1;
            end else if (bdc_s == DC_CMD) begin
                if (is_page_cmd(bdata_s)) begin
                    if (32'(bdata_s[2:0]) < PAGES) begin
                        page_d = bdata_s[2:0];
                    end else begin
                        page_d = page_q;
                    end
                end else if (is_col_lo_cmd(bdata_s)) begin
                    col_d = {col_q[6:4], bdata_s[3:0]};
                end else if (is_col_hi_cmd(bdata_s)) begin
                    col_d = {bdata_s[2:0], col_q[3:0]};
                end else begin
                    page_d = page_q;
                    col_d  = col_q;
                end
            end else begin
                we_d = 1'b0;
            end
        end else begin
            we_d = 1'b0;
        end
    end

    assign rx_io.byte_valid = bv_s;
    assign rx_io.byte_data  = bdata_s;
    assign rx_io.byte_dc    = bdc_s;
    assign rx_io.frame_err  = ferr_s;
    assign rx_io.gram_we    = we_q;
    assign rx_io.gram_addr  = addr_q;
    assign rx_io.gram_wdata = wdata_q;
    assign rx_io.cur_page   = page_q;
    assign rx_io.cur_col    = col_q;

endmodule

// File: tb/tb_oled_spi_rx.sv
// -----------------------------------------------------------------------------
// tb_oled_spi_rx
// Directed, table-driven bench for oled_spi_rx: addressing command vectors
// with hand-computed pointers and GRAM addresses, plus sequences for deselect
// timing, aborted bytes, display reset, mid-byte reset and a full clear.
// -----------------------------------------------------------------------------
module tb_oled_spi_rx;
    import oled_pkg::*;

    logic clk;
    logic rst;

    oled_spi_rx_if bus ();

    oled_spi_rx dut (
        .clk   (clk),
        .rst   (rst),
        .rx_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Free-running cycle counter.
    always @(posedge clk) cyc <= cyc + 1;

    int         bv_cnt   = 0;
    int         bv_cyc   = 0;
    int         wr_cnt   = 0;
    int         we_cyc   = 0;
    logic [9:0] wr_addr  = 10'd0;
    logic [7:0] wr_data  = 8'h00;
    bit         clear_phase = 1'b0;
    bit         written [1024];
    int         clear_nz = 0;

    // Observe strobes away from the active edge.
    always @(negedge clk) begin
        if (bus.byte_valid) begin
            bv_cnt <= bv_cnt + 1;
            bv_cyc <= cyc;
        end
        if (bus.gram_we) begin
            wr_cnt  <= wr_cnt + 1;
            we_cyc  <= cyc;
            wr_addr <= bus.gram_addr;
            wr_data <= bus.gram_wdata;
            if (clear_phase) begin
                written[bus.gram_addr] <= 1'b1;
                if (bus.gram_wdata != 8'h00) clear_nz <= clear_nz + 1;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // One cs_n frame of nbits MSB-first bits; hp = sclk half period in clks.
    task automatic send(input logic [7:0] b, input logic dcv, input int nbits,
                        input int hp, input bit cs_at_last, output int t_last);
        logic [7:0] sh;
        sh = b;
        t_last = -1;
        @(negedge clk);
        bus.cs_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            bus.sdin = sh[7];
            bus.dc   = dcv;
            sh = {sh[6:0], 1'b0};
            repeat (hp) @(negedge clk);
            bus.sclk = 1'b1;
            t_last = cyc;
            if (cs_at_last && (i == nbits - 1)) bus.cs_n = 1'b1;
            repeat (hp) @(negedge clk);
            bus.sclk = 1'b0;
        end
        repeat (2) @(negedge clk);
        bus.cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] b;
        logic       dcv;
        logic [2:0] page;
        logic [6:0] col;
        bit         wr;
        logic [9:0] addr;
    } vec_t;

    vec_t vecs [12];

    initial begin
        int t8;
        int bv0;
        int wr0;
        int missing;

        vecs[0]  = '{8'hB3, 1'b0, 3'd3, 7'd0,   1'b0, 10'd0};
        vecs[1]  = '{8'hB2, 1'b0, 3'd2, 7'd0,   1'b0, 10'd0};
        vecs[2]  = '{8'h05, 1'b0, 3'd2, 7'h05,  1'b0, 10'd0};
        vecs[3]  = '{8'h11, 1'b0, 3'd2, 7'h15,  1'b0, 10'd0};
        vecs[4]  = '{8'hA5, 1'b1, 3'd2, 7'h16,  1'b1, 10'd277};
        vecs[5]  = '{8'hAE, 1'b0, 3'd2, 7'h16,  1'b0, 10'd0};
        vecs[6]  = '{8'h18, 1'b0, 3'd2, 7'h16,  1'b0, 10'd0};
        vecs[7]  = '{8'hB7, 1'b0, 3'd7, 7'h16,  1'b0, 10'd0};
        vecs[8]  = '{8'h0F, 1'b0, 3'd7, 7'h1F,  1'b0, 10'd0};
        vecs[9]  = '{8'h17, 1'b0, 3'd7, 7'h7F,  1'b0, 10'd0};
        vecs[10] = '{8'h01, 1'b1, 3'd7, 7'd0,   1'b1, 10'd1023};
        vecs[11] = '{8'h02, 1'b1, 3'd7, 7'd1,   1'b1, 10'd896};

        rst          = 1'b1;
        bus.cs_n     = 1'b1;
        bus.sclk     = 1'b0;
        bus.dc       = 1'b0;
        bus.sdin     = 1'b0;
        bus.oled_rst = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_byte_valid", int'(bus.byte_valid), 0);
        check("rst_byte_data",  int'(bus.byte_data),  0);
        check("rst_byte_dc",    int'(bus.byte_dc),    0);
        check("rst_gram_we",    int'(bus.gram_we),    0);
        check("rst_gram_addr",  int'(bus.gram_addr),  0);
        check("rst_gram_wdata", int'(bus.gram_wdata), 0);
        check("rst_cur_page",   int'(bus.cur_page),   0);
        check("rst_cur_col",    int'(bus.cur_col),    0);
        check("rst_frame_err",  int'(bus.frame_err),  0);
        rst = 1'b0;
        repeat (6) @(negedge clk);

        // Command / data vectors at sclk = clk/10.
        for (int k = 0; k < 12; k++) begin
            bv0 = bv_cnt;
            wr0 = wr_cnt;
            send(vecs[k].b, vecs[k].dcv, 8, 5, 1'b0, t8);
            check("byte_count", bv_cnt - bv0, 1);
            check("byte_data",  int'(bus.byte_data), int'(vecs[k].b));
            check("byte_dc",    int'(bus.byte_dc),   int'(vecs[k].dcv));
            check("bv_latency", bv_cyc, t8 + 3);
            check("cur_page",   int'(bus.cur_page),  int'(vecs[k].page));
            check("cur_col",    int'(bus.cur_col),   int'(vecs[k].col));
            check("write_count", wr_cnt - wr0, vecs[k].wr ? 1 : 0);
            if (vecs[k].wr) begin
                check("gram_addr",  int'(wr_addr), int'(vecs[k].addr));
                check("gram_wdata", int'(wr_data), int'(vecs[k].b));
                check("we_latency", we_cyc, bv_cyc + 1);
            end
        end

        // cs_n rises together with the 8th sclk edge: byte still reported.
        bv0 = bv_cnt;
        send(8'h5A, 1'b0, 8, 5, 1'b1, t8);
        check("coinc_byte_count", bv_cnt - bv0, 1);
        check("coinc_byte_data",  int'(bus.byte_data), 8'h5A);
        check("coinc_frame_err",  int'(bus.frame_err), 0);

        // Aborted 5-bit frame then a clean 0x3C.
        bv0 = bv_cnt;
        send(8'hFF, 1'b0, 5, 5, 1'b0, t8);
        check("abort_byte_count", bv_cnt - bv0, 0);
        check("abort_frame_err",  int'(bus.frame_err), 1);
        send(8'h3C, 1'b0, 8, 5, 1'b0, t8);
        check("after_abort_data", int'(bus.byte_data), 8'h3C);
        check("after_abort_cnt",  bv_cnt - bv0, 1);
        check("frame_err_sticky", int'(bus.frame_err), 1);

        // Display reset holds everything.
        bus.oled_rst = 1'b0;
        repeat (5) @(negedge clk);
        check("orst_page_forced", int'(bus.cur_page), 0);
        check("orst_col_forced",  int'(bus.cur_col),  0);
        bv0 = bv_cnt;
        wr0 = wr_cnt;
        send(8'hB5, 1'b0, 8, 5, 1'b0, t8);
        send(8'h77, 1'b1, 8, 5, 1'b0, t8);
        check("orst_byte_count",  bv_cnt - bv0, 0);
        check("orst_write_count", wr_cnt - wr0, 0);
        check("orst_page",        int'(bus.cur_page), 0);
        check("orst_col",         int'(bus.cur_col),  0);
        bus.oled_rst = 1'b1;
        repeat (5) @(negedge clk);
        wr0 = wr_cnt;
        send(8'hFF, 1'b1, 8, 5, 1'b0, t8);
        check("post_orst_writes", wr_cnt - wr0, 1);
        check("post_orst_addr",   int'(wr_addr), 0);
        check("post_orst_wdata",  int'(wr_data), 8'hFF);
        check("post_orst_col",    int'(bus.cur_col), 1);

        // rst in the middle of a byte.
        bv0 = bv_cnt;
        @(negedge clk);
        bus.cs_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            bus.sdin = 1'b1;
            repeat (5) @(negedge clk);
            bus.sclk = 1'b1;
            repeat (5) @(negedge clk);
            bus.sclk = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        check("midrst_frame_err", int'(bus.frame_err), 0);
        check("midrst_col",       int'(bus.cur_col),   0);
        @(negedge clk);
        rst = 1'b0;
        bus.cs_n = 1'b1;
        repeat (10) @(negedge clk);
        check("midrst_byte_count", bv_cnt - bv0, 0);
        check("midrst_frame_err2", int'(bus.frame_err), 0);
        send(8'h12, 1'b0, 8, 5, 1'b0, t8);
        check("midrst_next_data", int'(bus.byte_data), 8'h12);
        check("midrst_next_col",  int'(bus.cur_col),   8'h20);

        // Full-screen clear at sclk = clk/6: 8 pages x 129 zero bytes.
        wr0 = wr_cnt;
        clear_phase = 1'b1;
        for (int p = 0; p < 8; p++) begin
            send(8'hB0 | 8'(p), 1'b0, 8, 3, 1'b0, t8);
            send(8'h00, 1'b0, 8, 3, 1'b0, t8);
            send(8'h10, 1'b0, 8, 3, 1'b0, t8);
            for (int c = 0; c < 129; c++) begin
                send(8'h00, 1'b1, 8, 3, 1'b0, t8);
            end
        end
        clear_phase = 1'b0;
        missing = 0;
        for (int a = 0; a < 1024; a++) begin
            if (!written[a]) missing++;
        end
        check("clear_writes",   wr_cnt - wr0, 1032);
        check("clear_missing",  missing, 0);
        check("clear_nonzero",  clear_nz, 0);
        check("clear_page",     int'(bus.cur_page), 7);
        check("clear_col",      int'(bus.cur_col),  1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/oled_spi_rx.md
# oled_spi_rx

Receive-side counterpart of the OLED 4-wire SPI transmitter (cs_n, sclk, dc, sdin, oled_rst). The block oversamples the serial lines in the fast system clock, reassembles bytes, and splits them into commands and display data. It tracks the page and column addressing commands and emits one GRAM write per data byte. Its uses are loopback self-check of the OLED driver path on hardware and a cycle-accurate display model in simulation.

## Interface
Parameters:
- SYNC_STAGES, 2: synchronizer depth on every serial input (min 2).
- COLS, 128: columns per page; column wraps at COLS.
- PAGES, 8: number of pages; GRAM depth = COLS*PAGES.

Ports:
- clk  in  1  system clock (10 MHz nominal). Must be at least 6x the sclk frequency.
- rst  in  1  synchronous, active-high reset. The block has one clock; reset is synchronous and active-high.
- cs_n  in  1  SPI chip select, active low. Asynchronous to clk.
- sclk  in  1  SPI clock; data is sampled on the rising edge.
- dc  in  1  1 = display data, 0 = command.
- sdin  in  1  serial data, MSB first.
- oled_rst  in  1  display reset, active low.
- byte_valid  out  1  one-clk pulse for each received byte.
- byte_data  out  8  received byte; held until the next byte.
- byte_dc  out  1  dc value sampled with bit 0 of the byte.
- gram_we  out  1  one-clk GRAM write strobe.
- gram_addr  out  10  write address, page*COLS + column.
- gram_wdata  out  8  write data.
- cur_page  out  3  current page pointer.
- cur_col  out  7  current column pointer.
- frame_err  out  1  sticky flag: cs_n rose while a byte was only partly received.

## Operation
- Every serial input passes through its own SYNC_STAGES flop chain. An sclk rising edge is detected from the last two synchronized samples.
- Shifter:
  - On each detected rising edge while synchronized cs_n is 0: shift_reg <= {shift_reg[6:0], sdin_s} and bit_cnt increments.
  - When bit_cnt goes 7 -> 0, pulse byte_valid and capture byte_data and byte_dc.
- Deassertion of cs_n:
  - bit_cnt clears and the partial bits are discarded.
  - If bit_cnt was nonzero, frame_err sets. Only rst clears it.
- While synchronized oled_rst is 0:
  - The shifter and bit_cnt are held clear.
  - cur_page and cur_col are forced to 0.
  - No byte_valid and no gram_we are produced.
- Command decode, on byte_valid with byte_dc = 0:
  - 0xB0–0xB7: cur_page <= byte[2:0].
  - 0x00–0x0F: cur_col[3:0] <= byte[3:0].
  - 0x10–0x17: cur_col[6:4] <= byte[2:0].
  - 0x18–0x1F: ignored, since the column would be at or above 128.
  - All other commands (for example 0xAE, 0x8D, 0xA1, 0xAF): no effect on pointers and no write.
- Data, on byte_valid with byte_dc = 1:
  - Issue one GRAM write at {cur_page, cur_col} with the byte as data.
  - Then cur_col <= (cur_col == COLS-1) ? 0 : cur_col+1. This is page addressing mode: cur_page does not change.
- Control states: IDLE (cs_n high) -> SHIFT (cs_n low) -> IDLE on cs_n high. DECODE is a single-cycle action on byte_valid, not a wait state.

## Timing
- Reset values:
  - byte_valid, gram_we, frame_err = 0.
  - byte_data, byte_dc, gram_addr, gram_wdata = 0.
  - cur_page, cur_col = 0.
  - All synchronizer flops reset to the idle levels: cs_n = 1, sclk = 0, dc = 0, sdin = 0, oled_rst = 0.
- Latency:
  - byte_valid asserts SYNC_STAGES+1 clks after the 8th sclk rising edge at the pin.
  - gram_we asserts exactly 1 clk after its byte_valid.
  - cur_page and cur_col update in the same cycle as gram_we, or 1 clk after byte_valid for commands.
- cs_n rising in the same clk as the 8th-bit edge detection: the byte completes and is reported, and frame_err is not set.
- Minimum spacing between consecutive bytes is 8 sclk periods, so at most one GRAM write is in flight and no buffering is required.
- rst asserted mid-byte: all state clears on the next clk edge, and no partial byte is reported after rst falls.

## Structure
- Shared package, oled_pkg:
  - DC_DATA = 1, DC_CMD = 0.
  - Command constants: CMD_PAGE_BASE 0xB0, CMD_COL_LO 0x00, CMD_COL_HI 0x10.
  - OLED_COLS and OLED_PAGES.
- One sub-module: oled_spi_rx_shifter. It contains the synchronizers, edge detect, shifter and frame_err, and outputs byte_valid, byte_data and byte_dc. The top level holds the command decode, the pointers and the GRAM write port.

## Test plan
- Basic command: send 0xB3 with dc = 0 and sclk = clk/10 -> byte_valid with byte_data = 0xB3 and byte_dc = 0, then cur_page = 3 and no gram_we.
- Positioned write: send 0xB2, 0x05, 0x11, then data 0xA5 with dc = 1 -> gram_we with gram_addr = 2*128 + 0x15 = 277 and gram_wdata = 0xA5; afterwards cur_col = 0x16.
- Column wrap: set page 7 and column 127, then send data 0x01 and 0x02 -> writes at addresses 1023 and 896; cur_page stays 7 and cur_col = 1.
- Aborted byte: cs_n falls, 5 bits are clocked, cs_n rises, then a full byte 0x3C follows -> frame_err = 1, and the next byte_data is 0x3C, not corrupted.
- Display reset: oled_rst = 0 while 0xB5 and data bytes are sent -> no byte_valid, no gram_we, and both pointers = 0. Release oled_rst and send data 0xFF -> write at address 0.
- Full-screen clear as the driver sends it (8 pages x 129 zero bytes) -> 1032 writes in total; columns wrap, so every address 0–1023 is written at least once.
